// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funct codes,
// ALU operations, controller states, instruction classes and datapath select codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4,
        ALU_LUI = 3'd5
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_TRAP     = 4'd15
    } state_e;

    typedef enum logic [3:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_ILLEGAL
    } iclass_e;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mc_ctrl_if.sv
// Bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface mc_ctrl_if;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        pc_write;
    logic        ir_write;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        regdst;
    logic        r31;
    logic [1:0]  wb_sel;
    logic        alusrc_a;
    logic [1:0]  alusrc_b;
    logic        extop;
    logic [2:0]  aluop;
    logic [1:0]  pcsrc;
    logic        illegal;
    logic [3:0]  state;
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               regdst, r31, wb_sel, alusrc_a, alusrc_b, extop, aluop,
               pcsrc, illegal, state, cycle_cnt, instr_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               regdst, r31, wb_sel, alusrc_a, alusrc_b, extop, aluop,
               pcsrc, illegal, state, cycle_cnt, instr_cnt
    );

endinterface

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction classifier: op/funct -> instruction class,
// ALU operation, immediate extension mode and an illegal-instruction flag.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output iclass_e    o_cls,
    output aluop_e     o_aluop,
    output logic       o_extop,
    output logic       o_illegal
);

    always_comb begin
        o_cls   = CLS_ILLEGAL;
        o_aluop = ALU_ADD;
        o_extop = 1'b0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU, FN_ADD: begin o_cls = CLS_RTYPE; o_aluop = ALU_ADD; end
                    FN_SUBU:         begin o_cls = CLS_RTYPE; o_aluop = ALU_SUB; end
                    FN_AND:          begin o_cls = CLS_RTYPE; o_aluop = ALU_AND; end
                    FN_OR:           begin o_cls = CLS_RTYPE; o_aluop = ALU_OR;  end
                    FN_SLT:          begin o_cls = CLS_RTYPE; o_aluop = ALU_SLT; end
                    FN_JR:           o_cls = CLS_JR;
                    default:         o_cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin o_cls = CLS_ITYPE; o_aluop = ALU_ADD; o_extop = 1'b1; end
            OP_ANDI:           begin o_cls = CLS_ITYPE; o_aluop = ALU_AND; end
            OP_ORI:            begin o_cls = CLS_ITYPE; o_aluop = ALU_OR;  end
            OP_LUI:            begin o_cls = CLS_ITYPE; o_aluop = ALU_LUI; end
            OP_LW:             begin o_cls = CLS_LW; o_extop = 1'b1; end
            OP_SW:             begin o_cls = CLS_SW; o_extop = 1'b1; end
            OP_BEQ:            o_cls = CLS_BEQ;
            OP_J:              o_cls = CLS_J;
            OP_JAL:            o_cls = CLS_JAL;
            default:           o_cls = CLS_ILLEGAL;
        endcase
    end

    assign o_illegal = (o_cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: state register, next-state logic and output decode.
// Optional performance counters are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mc_ctrl_if.master bus
);

    state_e  r_state;
    state_e  w_next;
    iclass_e w_cls;
    aluop_e  w_aluop;
    logic    w_extop;
    logic    w_illegal;

    mc_ctrl_dec u_dec (
        .i_op      (bus.op),
        .i_funct   (bus.funct),
        .o_cls     (w_cls),
        .o_aluop   (w_aluop),
        .o_extop   (w_extop),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal) begin
                    w_next = S_TRAP;
                end else begin
                    case (w_cls)
                        CLS_RTYPE:              w_next = S_EXEC_R;
                        CLS_ITYPE:              w_next = S_EXEC_I;
                        CLS_LW, CLS_SW:         w_next = S_MEM_ADDR;
                        CLS_BEQ:                w_next = S_BRANCH;
                        CLS_J, CLS_JAL, CLS_JR: w_next = S_JUMP;
                        default:                w_next = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
            S_MEM_ADDR: w_next = (w_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) w_next = S_MEM_WB;
            S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
            default:    w_next = S_TRAP;
        endcase
    end

    // Outputs are gated by rst so FETCH's mem_read cannot leak out during reset.
    always_comb begin
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.iord      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.reg_write = 1'b0;
        bus.regdst    = 1'b0;
        bus.r31       = 1'b0;
        bus.wb_sel    = WB_ALUOUT;
        bus.alusrc_a  = 1'b0;
        bus.alusrc_b  = SRCB_RT;
        bus.extop     = 1'b0;
        bus.aluop     = ALU_ADD;
        bus.pcsrc     = PC_ALU;
        bus.illegal   = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    bus.mem_read = 1'b1;
                    bus.alusrc_b = SRCB_FOUR;
                    bus.ir_write = bus.mem_ready;
                    bus.pc_write = bus.mem_ready;
                end
                S_DECODE: bus.alusrc_b = SRCB_BRANCH;
                S_EXEC_R: begin
                    bus.alusrc_a = 1'b1;
                    bus.aluop    = w_aluop;
                end
                S_EXEC_I: begin
                    bus.alusrc_a = 1'b1;
                    bus.alusrc_b = SRCB_IMM;
                    bus.extop    = w_extop;
                    bus.aluop    = w_aluop;
                end
                S_ALU_WB: begin
                    bus.reg_write = 1'b1;
                    bus.regdst    = (w_cls == CLS_RTYPE);
                end
                S_MEM_ADDR: begin
                    bus.alusrc_a = 1'b1;
                    bus.alusrc_b = SRCB_IMM;
                    bus.extop    = 1'b1;
                end
                S_MEM_RD: begin
                    bus.mem_read = 1'b1;
                    bus.iord     = 1'b1;
                end
                S_MEM_WB: begin
                    bus.reg_write = 1'b1;
                    bus.wb_sel    = WB_MDR;
                end
                S_MEM_WR: begin
                    bus.mem_write = 1'b1;
                    bus.iord      = 1'b1;
                end
                S_BRANCH: begin
                    bus.alusrc_a = 1'b1;
                    bus.aluop    = ALU_SUB;
                    bus.pcsrc    = PC_ALUOUT;
                    bus.pc_write = bus.zero;
                end
                S_JUMP: begin
                    bus.pc_write = 1'b1;
                    bus.pcsrc    = (w_cls == CLS_JR) ? PC_RS : PC_JUMP;
                    if (w_cls == CLS_JAL) begin
                        bus.reg_write = 1'b1;
                        bus.r31       = 1'b1;
                        bus.wb_sel    = WB_PC;
                    end
                end
                S_TRAP:  bus.illegal = 1'b1;
                default: bus.illegal = 1'b1;
            endcase
        end
    end

    assign bus.state = r_state;

`ifdef MC_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;
    logic        w_retire;

    // An instruction retires on the edge that carries a completing state back to FETCH.
    assign w_retire = (w_next == S_FETCH) &&
                      (r_state inside {S_ALU_WB, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt = r_cycle_cnt;
    assign bus.instr_cnt = r_instr_cnt;
`else
    assign bus.cycle_cnt = '0;
    assign bus.instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard testbench for mc_ctrl: stimulus pushes hand-computed per-cycle
// expectations, a monitor pops and compares them at each falling edge.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [63:0] tag;
        logic [3:0]  st;
        logic [19:0] ctl;
        logic [31:0] ic;
        logic [31:0] cc;
    } exp_t;

    logic clk;
    logic rst;
    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        expQ[$];
    event        monTick;
    int          checks;
    int          errors;
    logic [31:0] expInstr;
    logic [31:0] expCycles;

    logic [19:0] vReset, vFetch, vFetchW, vDec, vWbR, vWbI, vMemAddr, vMemRd;
    logic [19:0] vMemWb, vMemWr, vJ, vJal, vJr, vTrap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] mk(input logic pcw, irw, iord, mrd, mwr, rw, rdst, r31,
                                       input logic [1:0] wbs, input logic asa,
                                       input logic [1:0] asb, input logic ext,
                                       input logic [2:0] aop, input logic [1:0] pcs,
                                       input logic ill);
        return {pcw, irw, iord, mrd, mwr, rw, rdst, r31, wbs, asa, asb, ext, aop, pcs, ill};
    endfunction

    function automatic logic [19:0] exR(input logic [2:0] aop);
        return mk(0,0,0,0,0,0,0,0, 2'b00, 1, 2'b00, 0, aop, 2'b00, 0);
    endfunction

    function automatic logic [19:0] exI(input logic ext, input logic [2:0] aop);
        return mk(0,0,0,0,0,0,0,0, 2'b00, 1, 2'b10, ext, aop, 2'b00, 0);
    endfunction

    function automatic logic [19:0] vBr(input logic z);
        return mk(z,0,0,0,0,0,0,0, 2'b00, 1, 2'b00, 0, ALU_SUB, 2'b01, 0);
    endfunction

    task automatic applyStimulus(input logic rstV, input logic [5:0] opV, input logic [5:0] fnV,
                                 input logic zV, input logic mrV, input logic [63:0] tag,
                                 input logic [3:0] st, input logic [19:0] ctl, input bit retire);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rstV;
        bus.op        = opV;
        bus.funct     = fnV;
        bus.zero      = zV;
        bus.mem_ready = mrV;
        if (rstV) begin
            expInstr  = '0;
            expCycles = '0;
        end
        e.tag = tag;
        e.st  = st;
        e.ctl = ctl;
        e.ic  = PERF ? expInstr : 32'd0;
        e.cc  = PERF ? expCycles : 32'd0;
        expQ.push_back(e);
        if (!rstV) begin
            expCycles = expCycles + 32'd1;
            if (retire) expInstr = expInstr + 32'd1;
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [19:0] act;
        act = {bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
               bus.reg_write, bus.regdst, bus.r31, bus.wb_sel, bus.alusrc_a,
               bus.alusrc_b, bus.extop, bus.aluop, bus.pcsrc, bus.illegal};
        checks++;
        if ({bus.state, act} !== {e.st, e.ctl}) begin
            errors++;
            $display("[TB] FAIL %s ctl: got state=%0d ctl=%05h want state=%0d ctl=%05h",
                     e.tag, bus.state, act, e.st, e.ctl);
        end
        checks++;
        if ({bus.instr_cnt, bus.cycle_cnt} !== {e.ic, e.cc}) begin
            errors++;
            $display("[TB] FAIL %s cnt: got instr=%0d cyc=%0d want instr=%0d cyc=%0d",
                     e.tag, bus.instr_cnt, bus.cycle_cnt, e.ic, e.cc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or monTick);
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic runAlu(input logic [5:0] opV, input logic [5:0] fnV, input logic [63:0] tag,
                          input logic [3:0] exSt, input logic [19:0] exVec,
                          input logic [19:0] wbVec);
        applyStimulus(0, opV, fnV, 0, 1, tag, 4'd0, vFetch, 0);
        applyStimulus(0, opV, fnV, 0, 1, tag, 4'd1, vDec, 0);
        applyStimulus(0, opV, fnV, 0, 1, tag, exSt, exVec, 0);
        applyStimulus(0, opV, fnV, 0, 1, tag, 4'd4, wbVec, 1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        expInstr  = '0;
        expCycles = '0;
        rst           = 1'b1;
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        vReset   = '0;
        vFetch   = mk(1,1,0,1,0,0,0,0, 2'b00, 0, 2'b01, 0, ALU_ADD, 2'b00, 0);
        vFetchW  = mk(0,0,0,1,0,0,0,0, 2'b00, 0, 2'b01, 0, ALU_ADD, 2'b00, 0);
        vDec     = mk(0,0,0,0,0,0,0,0, 2'b00, 0, 2'b11, 0, ALU_ADD, 2'b00, 0);
        vWbR     = mk(0,0,0,0,0,1,1,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b00, 0);
        vWbI     = mk(0,0,0,0,0,1,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b00, 0);
        vMemAddr = mk(0,0,0,0,0,0,0,0, 2'b00, 1, 2'b10, 1, ALU_ADD, 2'b00, 0);
        vMemRd   = mk(0,0,1,1,0,0,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b00, 0);
        vMemWb   = mk(0,0,0,0,0,1,0,0, 2'b01, 0, 2'b00, 0, ALU_ADD, 2'b00, 0);
        vMemWr   = mk(0,0,1,0,1,0,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b00, 0);
        vJ       = mk(1,0,0,0,0,0,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b10, 0);
        vJal     = mk(1,0,0,0,0,1,0,1, 2'b10, 0, 2'b00, 0, ALU_ADD, 2'b10, 0);
        vJr      = mk(1,0,0,0,0,0,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b11, 0);
        vTrap    = mk(0,0,0,0,0,0,0,0, 2'b00, 0, 2'b00, 0, ALU_ADD, 2'b00, 1);

        // reset: FETCH with mem_read suppressed even though mem_ready is high
        applyStimulus(1, 6'b000000, 6'b000000, 0, 1, "reset", 4'd0, vReset, 0);
        applyStimulus(1, 6'b000000, 6'b000000, 0, 1, "reset", 4'd0, vReset, 0);

        // R-type and I-type ALU instructions
        runAlu(6'b000000, 6'b100001, "addu", 4'd2, exR(ALU_ADD), vWbR);
        runAlu(6'b000000, 6'b100011, "subu", 4'd2, exR(ALU_SUB), vWbR);
        runAlu(6'b000000, 6'b100100, "and",  4'd2, exR(ALU_AND), vWbR);
        runAlu(6'b000000, 6'b100101, "or",   4'd2, exR(ALU_OR),  vWbR);
        runAlu(6'b000000, 6'b101010, "slt",  4'd2, exR(ALU_SLT), vWbR);
        runAlu(6'b000000, 6'b100000, "add",  4'd2, exR(ALU_ADD), vWbR);
        runAlu(6'b001000, 6'b000000, "addi", 4'd3, exI(1, ALU_ADD), vWbI);
        runAlu(6'b001100, 6'b111111, "andi", 4'd3, exI(0, ALU_AND), vWbI);
        runAlu(6'b001101, 6'b000000, "ori",  4'd3, exI(0, ALU_OR),  vWbI);
        runAlu(6'b001111, 6'b000000, "lui",  4'd3, exI(0, ALU_LUI), vWbI);

        // addiu with two FETCH stall cycles
        applyStimulus(0, 6'b001001, 6'b000000, 0, 0, "addiuF", 4'd0, vFetchW, 0);
        applyStimulus(0, 6'b001001, 6'b000000, 0, 0, "addiuF", 4'd0, vFetchW, 0);
        runAlu(6'b001001, 6'b000000, "addiu", 4'd3, exI(1, ALU_ADD), vWbI);

        // lw with two stall cycles in MEM_RD
        applyStimulus(0, 6'b100011, 6'b000000, 0, 1, "lw", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 1, "lw", 4'd1, vDec, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 1, "lw", 4'd5, vMemAddr, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 0, "lwRd0", 4'd6, vMemRd, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 0, "lwRd1", 4'd6, vMemRd, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 1, "lwRd2", 4'd6, vMemRd, 0);
        applyStimulus(0, 6'b100011, 6'b000000, 0, 1, "lwWb", 4'd7, vMemWb, 1);

        // sw with no stall
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "sw", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "sw", 4'd1, vDec, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "sw", 4'd5, vMemAddr, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "swWr", 4'd8, vMemWr, 1);

        // beq taken and not taken
        applyStimulus(0, 6'b000100, 6'b000000, 1, 1, "beqT", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000100, 6'b000000, 1, 1, "beqT", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000100, 6'b000000, 1, 1, "beqT", 4'd9, vBr(1), 1);
        applyStimulus(0, 6'b000100, 6'b000000, 0, 1, "beqN", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000100, 6'b000000, 0, 1, "beqN", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000100, 6'b000000, 0, 1, "beqN", 4'd9, vBr(0), 1);

        // jumps
        applyStimulus(0, 6'b000010, 6'b000000, 0, 1, "j", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000010, 6'b000000, 0, 1, "j", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000010, 6'b000000, 0, 1, "j", 4'd10, vJ, 1);
        applyStimulus(0, 6'b000011, 6'b000000, 0, 1, "jal", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000011, 6'b000000, 0, 1, "jal", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000011, 6'b000000, 0, 1, "jal", 4'd10, vJal, 1);
        applyStimulus(0, 6'b000000, 6'b001000, 0, 1, "jr", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000000, 6'b001000, 0, 1, "jr", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000000, 6'b001000, 0, 1, "jr", 4'd10, vJr, 1);

        // sw stalled in MEM_WR, then asynchronous reset mid-cycle
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "swR", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "swR", 4'd1, vDec, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 1, "swR", 4'd5, vMemAddr, 0);
        applyStimulus(0, 6'b101011, 6'b000000, 0, 0, "swRWr", 4'd8, vMemWr, 0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expInstr  = '0;
        expCycles = '0;
        expQ.push_back('{tag: "rstAsync", st: 4'd0, ctl: vReset, ic: 32'd0, cc: 32'd0});
        ->monTick;
        applyStimulus(1, 6'b101011, 6'b000000, 0, 0, "rstHold", 4'd0, vReset, 0);

        // illegal opcode traps and holds regardless of mem_ready
        applyStimulus(0, 6'b111111, 6'b000000, 0, 1, "ill", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b111111, 6'b000000, 0, 1, "ill", 4'd1, vDec, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 6'b111111, 6'b000000, 0, i[0], "trap", 4'd15, vTrap, 0);
        applyStimulus(1, 6'b000000, 6'b000000, 0, 1, "trapRst", 4'd0, vReset, 0);

        // unsupported R-type funct also traps
        applyStimulus(0, 6'b000000, 6'b000000, 0, 1, "illFn", 4'd0, vFetch, 0);
        applyStimulus(0, 6'b000000, 6'b000000, 0, 1, "illFn", 4'd1, vDec, 0);
        applyStimulus(0, 6'b000000, 6'b000000, 0, 1, "illFnT", 4'd15, vTrap, 0);
        applyStimulus(1, 6'b000000, 6'b000000, 0, 1, "reset2", 4'd0, vReset, 0);
        applyStimulus(0, 6'b000000, 6'b100001, 0, 0, "idle", 4'd0, vFetchW, 0);

        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending entries want 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
